bht_predictor: RTL and testbench
================================

# bht_predictor

Parametrised dynamic branch predictor for the pipelined RISC-V core: a table of saturating counters, optionally gshare-indexed, that supplies the IF-stage taken prediction feeding `BrPre_if` and is trained by the ID-stage branch resolution. It generalises the fixed predictor with configurable depth, counter width and global-history mode, and adds mispredict statistics. The lookup path is combinational in IF. Training, history and statistics update on the clock edge.

## Interface
- `ENTRIES`, 16: counter-table depth. Must be a power of 2, at least 4. `IDX_W = log2(ENTRIES)`.
- `CNT_BITS`, 2: counter width, 1 to 4.
- `USE_GHR`, 0: 0 selects bimodal indexing, 1 selects gshare indexing.
- `GHR_BITS`, 4: global history length, 1 to `IDX_W`. Ignored when `USE_GHR`=0.
- `XLEN`, 32: PC width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pc_if` in XLEN: PC of the instruction in IF.
- `pred_taken` out 1: predicted direction for `pc_if`. Combinational.
- `pred_idx` out IDX_W: table index used for `pc_if`. Pipelined alongside the instruction.
- `upd_valid` in 1: a conditional branch (beq/bne) resolves in ID this cycle.
- `upd_stall` in 1: ID is stalled. While high, the update is ignored.
- `upd_idx` in IDX_W: the `pred_idx` that was carried with the resolving branch.
- `upd_taken` in 1: actual outcome of the branch (Ctrl_Br).
- `upd_mispred` in 1: the prediction was wrong (PreWrong).
- `ghr` out GHR_BITS: current global history. Debug only.
- `br_count` out 32: number of committed branch updates.
- `mis_count` out 32: number of committed mispredicts.

## Operation
- An update is committed in a cycle when `upd_valid & ~upd_stall` is high.
- Index calculation:
  - Bimodal: `idx = pc_if[IDX_W+1:2]`.
  - Gshare: the same PC bits, with the low `GHR_BITS` bits XORed with `ghr`.
- Prediction: `pred_taken` = MSB of `cnt[idx]`.
- Counter training on a committed update:
  - Taken: `cnt[upd_idx]` +1, saturating at `2^CNT_BITS-1`.
  - Not taken: `cnt[upd_idx]` −1, saturating at 0.
- History: on a committed update, `ghr <= {ghr[GHR_BITS-2:0], upd_taken}`. When `GHR_BITS`=1, `ghr <= upd_taken`. History is non-speculative: it is updated only at resolution, never at lookup.
- Statistics:
  - `br_count` +1 on each committed update.
  - `mis_count` +1 on each committed update that has `upd_mispred`=1.
  - Both saturate at `32'hFFFF_FFFF` and do not wrap.
- Training uses `upd_idx`, never a recomputed index. This keeps gshare coherent when `ghr` has changed between lookup and resolve.
- Reset values:
  - Every `cnt` is set to weakly-not-taken, `2^(CNT_BITS-1)-1`. For `CNT_BITS`=1 this is 0.
  - `ghr` = 0, `br_count` = 0, `mis_count` = 0.
  - Therefore after reset `pred_taken` = 0 for every PC.
- `upd_mispred` has no effect on the counters. It only drives the statistics.

## Timing
- Lookup has zero latency: `pred_taken` and `pred_idx` follow `pc_if` within the same cycle.
- A committed update is visible to lookups from the next cycle.
- Simultaneous lookup and update on the same index: the lookup returns the pre-update counter value. There is no bypass.
- Stalls: an update presented with `upd_stall`=1 is dropped. ID re-presents the held branch when the stall releases, so each branch commits exactly once.
- `rst` asserted mid-operation: all state returns to the reset values at that edge, and any update in the same cycle is discarded. `pred_taken` = 0 from the following cycle.
- All state is held in flip-flops, with no SRAM. The reset loop touches all `ENTRIES` counters in one cycle.

## Structure
- Shared package `bp_pkg`:
  - the `cnt_init(CNT_BITS)` function;
  - the saturating inc/dec functions;
  - the `BP_IDX_LSB = 2` constant.
- One sub-module, `sat_counter` (parameter `W`). It provides saturating increment/decrement with a synchronous load-init input and is instantiated once per entry. The statistics counters reuse it with `W=32`.
- Index/XOR logic stays in the top module, and is shared by the lookup and the debug path.

## Test plan
- Reset, then sweep `pc_if` from 0x0 to 0x3C in steps of 4: `pred_taken` must be 0 at every index, and `ghr`, `br_count` and `mis_count` must all be 0.
- Bimodal, ENTRIES=16, CNT_BITS=2, PC 0x40 (idx 0):
  - one taken update → counter 10, `pred_taken`=1 the next cycle;
  - three more taken updates → counter 11;
  - one not-taken update → counter 10, still taken;
  - a second not-taken update → counter 01, `pred_taken`=0.
- Aliasing: train PC 0x00 taken twice. PC 0x40 must then predict taken, because it shares idx 0.
- Gshare, GHR_BITS=4:
  - after updates T,T,N,T, `ghr` must equal 4'b1101;
  - for PC 0x10, `pred_idx` must equal 4'b0100 ^ 4'b1101 = 4'b1001.
- Update to idx 3 with `upd_stall`=1 for 3 cycles, then released: the counter changes exactly once, and `br_count` increments by 1.
- Same-cycle lookup and update of idx 5 from 01 with taken: the lookup returns 0 that cycle and 1 the next.
- `rst` pulsed during a taken update: the counter stays at 01, and `mis_count` is cleared.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared constants and saturating-counter helpers for the branch predictor
package bp_pkg;

    localparam int BP_IDX_LSB = 2;

    function automatic logic [31:0] cnt_init(input int bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v == max) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? v : v - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up/down counter that saturates at 0 and all-ones, with synchronous load of INIT
module sat_counter
    import bp_pkg::*;
#(
    parameter int             W    = 2,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic         clk,
    input  logic         init,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = '1;

    // load the init value, otherwise step toward the saturation limits
    always_ff @(posedge clk)
        if (init) q <= INIT;
        else if (inc) q <= W'(sat_inc(32'(q), 32'(MAX)));
        else if (dec) q <= W'(sat_dec(32'(q)));

endmodule

// File: rtl/bht_predictor.sv
// bht_predictor: bimodal/gshare table of saturating counters with resolution-time training and stats
module bht_predictor
    import bp_pkg::*;
#(
    parameter int  ENTRIES  = 16,
    parameter int  CNT_BITS = 2,
    parameter int  USE_GHR  = 0,
    parameter int  GHR_BITS = 4,
    parameter int  XLEN     = 32,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     pc_if,
    output logic                pred_taken,
    output logic [IDX_W-1:0]    pred_idx,
    input  logic                upd_valid,
    input  logic                upd_stall,
    input  logic [IDX_W-1:0]    upd_idx,
    input  logic                upd_taken,
    input  logic                upd_mispred,
    output logic [GHR_BITS-1:0] ghr,
    output logic [31:0]         br_count,
    output logic [31:0]         mis_count
);

    logic                commit;
    logic [IDX_W-1:0]    hist;
    logic [CNT_BITS-1:0] cnt [ENTRIES];
    logic                unused_pc;

    assign commit     = upd_valid & ~upd_stall;
    assign hist       = (USE_GHR != 0) ? IDX_W'(ghr) : '0;
    assign pred_idx   = pc_if[BP_IDX_LSB +: IDX_W] ^ hist;
    assign pred_taken = cnt[pred_idx][CNT_BITS-1];
    assign unused_pc  = ^{pc_if[XLEN-1:BP_IDX_LSB+IDX_W], pc_if[BP_IDX_LSB-1:0]};

    // non-speculative history: shift in the resolved outcome on commit only
    always_ff @(posedge clk)
        if (rst) ghr <= '0;
        else if (commit) ghr <= GHR_BITS'({ghr, upd_taken});

    for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
        sat_counter #(
            .W    (CNT_BITS),
            .INIT (CNT_BITS'(cnt_init(CNT_BITS)))
        ) u_cnt (
            .clk  (clk),
            .init (rst),
            .inc  (commit && upd_idx == IDX_W'(i) && upd_taken),
            .dec  (commit && upd_idx == IDX_W'(i) && !upd_taken),
            .q    (cnt[i])
        );
    end

    sat_counter #(.W(32), .INIT(32'd0)) u_br (
        .clk  (clk),
        .init (rst),
        .inc  (commit),
        .dec  (1'b0),
        .q    (br_count)
    );

    sat_counter #(.W(32), .INIT(32'd0)) u_mis (
        .clk  (clk),
        .init (rst),
        .inc  (commit & upd_mispred),
        .dec  (1'b0),
        .q    (mis_count)
    );

endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: scoreboard bench for bimodal and gshare predictor instances
module tb_bht_predictor;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_if = '0;
    logic        pred_taken;
    logic [3:0]  pred_idx;
    logic        upd_valid = 1'b0, upd_stall = 1'b0, upd_taken = 1'b0, upd_mispred = 1'b0;
    logic [3:0]  upd_idx = '0;
    logic [3:0]  ghr;
    logic [31:0] br_count, mis_count;

    logic [31:0] g_pc_if = '0;
    logic        g_pred_taken;
    logic [3:0]  g_pred_idx;
    logic        g_upd_valid = 1'b0, g_upd_taken = 1'b0;
    logic [3:0]  g_ghr;
    logic [31:0] g_br_count, g_mis_count;

    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0;
    logic [1:0]  mcnt [16];
    int          mbr = 0, mmis = 0;
    logic [3:0]  mghr = '0;

    always #5 clk = ~clk;

    bht_predictor u_dut (
        .clk         (clk),
        .rst         (rst),
        .pc_if       (pc_if),
        .pred_taken  (pred_taken),
        .pred_idx    (pred_idx),
        .upd_valid   (upd_valid),
        .upd_stall   (upd_stall),
        .upd_idx     (upd_idx),
        .upd_taken   (upd_taken),
        .upd_mispred (upd_mispred),
        .ghr         (ghr),
        .br_count    (br_count),
        .mis_count   (mis_count)
    );

    bht_predictor #(.USE_GHR(1), .GHR_BITS(4)) u_gs (
        .clk         (clk),
        .rst         (rst),
        .pc_if       (g_pc_if),
        .pred_taken  (g_pred_taken),
        .pred_idx    (g_pred_idx),
        .upd_valid   (g_upd_valid),
        .upd_stall   (1'b0),
        .upd_idx     (4'd0),
        .upd_taken   (g_upd_taken),
        .upd_mispred (1'b0),
        .ghr         (g_ghr),
        .br_count    (g_br_count),
        .mis_count   (g_mis_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", obs, 32'hxxxx_xxxx);
        end else begin
            e = sb.pop_front();
            check_val(e.tag, obs, e.v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mcnt[i] = 2'b01;
        mbr  = 0;
        mmis = 0;
    endtask

    task automatic commit(input logic [3:0] idx, input logic t, input logic m);
        upd_valid   = 1'b1;
        upd_idx     = idx;
        upd_taken   = t;
        upd_mispred = m;
        tick();
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
        if (t) mcnt[idx] = (mcnt[idx] == 2'b11) ? 2'b11 : mcnt[idx] + 2'b01;
        else   mcnt[idx] = (mcnt[idx] == 2'b00) ? 2'b00 : mcnt[idx] - 2'b01;
        mbr++;
        if (m) mmis++;
    endtask

    task automatic expect_pred(input logic [31:0] pc);
        pc_if = pc;
        #1;
        push_exp($sformatf("pred_pc_%0h", pc), 32'(mcnt[pc[5:2]][1]));
        pop_chk(32'(pred_taken));
    endtask

    task automatic expect_stats();
        push_exp("br_count", 32'(mbr));
        push_exp("mis_count", 32'(mmis));
        pop_chk(br_count);
        pop_chk(mis_count);
    endtask

    task automatic gcommit(input logic t);
        g_upd_valid = 1'b1;
        g_upd_taken = t;
        tick();
        g_upd_valid = 1'b0;
        mghr = {mghr[2:0], t};
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        for (int p = 0; p <= 32'h3C; p += 4) expect_pred(32'(p));
        push_exp("ghr_reset", 32'd0);
        pop_chk(32'(ghr));
        expect_stats();

        commit(4'd0, 1'b1, 1'b1);
        expect_pred(32'h40);
        for (int k = 0; k < 3; k++) commit(4'd0, 1'b1, 1'b0);
        expect_pred(32'h40);
        commit(4'd0, 1'b0, 1'b1);
        expect_pred(32'h40);
        commit(4'd0, 1'b0, 1'b0);
        expect_pred(32'h40);
        push_exp("idx0_after_two_not_taken", 32'd0);
        pop_chk(32'(pred_taken));
        expect_stats();

        commit(4'd0, 1'b1, 1'b0);
        commit(4'd0, 1'b1, 1'b0);
        expect_pred(32'h40);
        push_exp("alias_pc40_taken", 32'd1);
        pop_chk(32'(pred_taken));

        pc_if = 32'h10;
        #1;
        push_exp("bimodal_pred_idx", 32'd4);
        pop_chk(32'(pred_idx));

        for (int k = 0; k < 3; k++) commit(4'd7, 1'b0, 1'b0);
        commit(4'd7, 1'b1, 1'b0);
        expect_pred(32'h1C);

        upd_valid = 1'b1;
        upd_stall = 1'b1;
        upd_idx   = 4'd3;
        upd_taken = 1'b1;
        repeat (3) tick();
        expect_pred(32'h0C);
        expect_stats();
        upd_stall = 1'b0;
        commit(4'd3, 1'b1, 1'b0);
        expect_pred(32'h0C);
        expect_stats();

        pc_if     = 32'h14;
        upd_valid = 1'b1;
        upd_idx   = 4'd5;
        upd_taken = 1'b1;
        #1;
        push_exp("same_cycle_pre_update", 32'd0);
        pop_chk(32'(pred_taken));
        commit(4'd5, 1'b1, 1'b0);
        push_exp("same_cycle_next", 32'd1);
        pop_chk(32'(pred_taken));

        commit(4'd2, 1'b1, 1'b1);
        expect_stats();
        rst       = 1'b1;
        upd_valid = 1'b1;
        upd_idx   = 4'd6;
        upd_taken = 1'b1;
        tick();
        rst       = 1'b0;
        upd_valid = 1'b0;
        model_reset();
        expect_pred(32'h18);
        expect_pred(32'h40);
        expect_stats();

        gcommit(1'b1);
        gcommit(1'b1);
        gcommit(1'b0);
        gcommit(1'b1);
        push_exp("gshare_ghr", 32'(mghr));
        push_exp("gshare_ghr_const", 32'hD);
        pop_chk(32'(g_ghr));
        pop_chk(32'(g_ghr));
        g_pc_if = 32'h10;
        #1;
        push_exp("gshare_pred_idx", 32'(4'b0100 ^ mghr));
        pop_chk(32'(g_pred_idx));
        push_exp("gshare_br_count", 32'd4);
        pop_chk(g_br_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
